hermes_vc_switch: RTL and testbench
===================================

# hermes_vc_switch

Parametrised Hermes switch control with virtual channels and selectable dimension order. It arbitrates header requests from all input channels (port × VC) with a round-robin arbiter. It routes each header by XY or YX order, or by an explicit forced port, and allocates the same VC on the chosen output port. The block sits beside the per-channel input buffers and the crossbar of a router, driving the crossbar selects and the per-channel free flags.

## Interface
Port indices are fixed: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4 (NPORT=5). Channel index c = port*NVC + vc, NCH = 5*NVC, CH_W = $clog2(NCH).
- ADDRESS, 16'h0000: router coordinate; X = ADDRESS[2*COORD_W-1:COORD_W], Y = ADDRESS[COORD_W-1:0].
- FLIT_SIZE, 32: flit width; minimum 2*COORD_W+4.
- COORD_W, 8: bits per coordinate.
- NVC, 2: virtual channels per port (1..4).
- YX_ROUTING, 0: 0 = X then Y; 1 = Y then X.
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset; asynchronous, active-low.
- req_i, input, [NCH]: input channel c holds a header and requests routing.
- sending_i, input, [NCH]: input channel c is forwarding a packet. A falling edge marks the end of the packet.
- data_i, input, [NCH][FLIT_SIZE]: head flit of each input channel.
- ack_o, output, [NCH]: one-cycle routing grant to input channel c.
- free_o, output, [NCH]: output channel c is unallocated.
- outport_o, output, [NCH][3]: output port assigned to input channel c.
- inport_o, output, [NCH][CH_W]: input channel driving output channel c.

## Operation
- Header decode for the selected channel s:
  - target = data_i[s][2*COORD_W-1:0]; tx = upper half, ty = lower half.
  - force = data_i[s][FLIT_SIZE-1]; fport = data_i[s][FLIT_SIZE-2:FLIT_SIZE-4]. fport values 5..7 map to LOCAL.
- Route:
  - Forced packets use fport.
  - Otherwise, with XY order: tx≠X → EAST if tx>X else WEST; else ty≠Y → NORTH if ty>Y else SOUTH; else LOCAL.
  - YX order checks Y first, then X.
  - Comparisons are unsigned.
- Output channel o = route*NVC + (s mod NVC). VC is preserved hop to hop.
- Round-robin: next = first requesting channel after sel, in ascending order with wrap, with sel itself considered last. With no requests, next = sel.
- FSM states and transitions:
  - IDLE → ARBIT if any req_i.
  - ARBIT: sel ← next → ROUTE.
  - ROUTE: if !req_i[sel] → IDLE; else if free_o[o] → GRANT; else → ARBIT. Retrying through ARBIT advances past blocked channels.
  - GRANT: outport_o[sel] ← route; inport_o[o] ← sel; free_o[o] ← 0 → ACK.
  - ACK: ack_o[sel]=1 for this cycle only → IDLE.
- Release: sending_i[c] registered. When sending_r[c] & !sending_i[c], free_o[outport_o[c]] ← 1. Multiple releases in one cycle are all applied.
- Simultaneous GRANT clear and release of the same output channel: the clear wins.
- Reset values: state IDLE, sel 0, every free_o 1, outport_o 0 (EAST), inport_o 0, sending_r 0, ack_o 0.
- Reset mid-operation discards any pending grant; no ack_o is issued afterwards.

## Timing
- Request seen in IDLE at cycle 0 → ARBIT in cycle 1, ROUTE in cycle 2, GRANT in cycle 3, ack_o high in cycle 4. Minimum latency is 4 cycles.
- outport_o, inport_o and free_o update at the end of the GRANT cycle and are stable while ack_o is high.
- A blocked route costs 2 cycles per retry (ROUTE → ARBIT → ROUTE).
- ack_o is combinational from state and sel and is one-hot or zero.
- At most one grant per 5 cycles.
- A release is visible on free_o 1 cycle after the falling edge of sending_i.
- An input must hold req_i and data_i until ack_o.

## Test plan
- NVC=2, ADDRESS=16'h0101, XY: req on channel 8 (LOCAL vc0), target 16'h0301 → ack_o[8] in cycle 4, outport_o[8]=0, inport_o[0]=8, free_o[0]=0.
- Same header with YX_ROUTING=1 and target 16'h0303 → outport=NORTH(2), output channel 4 (vc0); with XY the same header goes EAST.
- Channels 0, 3 and 9 request continuously, every route free and released at once → grant order 3, 9, 0, 3, … with sel starting at 0.
- Output channel 0 busy; channels 8 (→EAST) and 2 (→LOCAL) request → channel 8 is skipped and channel 2 granted. After sending_i[c] falls for the holder of channel 0, channel 8 is granted.
- Forced header, fport=7 → LOCAL. Forced header with target ≠ address and fport=3 → SOUTH regardless of target.
- Assert rst_ni low during GRANT → no ack_o, all free_o=1, all outport_o=0; req held → normal grant 4 cycles after release of reset.

Source files
------------

// File: rtl/hermes_vc_switch.sv
// Hermes router switch control with virtual channels: round-robin header arbitration,
// XY/YX/forced routing, same-VC output allocation and end-of-packet release.
module hermes_vc_switch #(
    parameter int unsigned                COORD_W    = 8,
    parameter logic [2*COORD_W-1:0]       ADDRESS    = 16'h0000,
    parameter int unsigned                FLIT_SIZE  = 32,
    parameter int unsigned                NVC        = 2,
    parameter int unsigned                YX_ROUTING = 0,
    parameter int unsigned                NCH        = 5 * NVC,
    parameter int unsigned                CH_W       = $clog2(NCH)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NCH-1:0]                    req_i,
    input  logic [NCH-1:0]                    sending_i,
    input  logic [NCH-1:0][FLIT_SIZE-1:0]     data_i,
    output logic [NCH-1:0]                    ack_o,
    output logic [NCH-1:0]                    free_o,
    output logic [NCH-1:0][2:0]               outport_o,
    output logic [NCH-1:0][CH_W-1:0]          inport_o
);

    localparam logic [2:0] PORT_EAST  = 3'd0;
    localparam logic [2:0] PORT_WEST  = 3'd1;
    localparam logic [2:0] PORT_NORTH = 3'd2;
    localparam logic [2:0] PORT_SOUTH = 3'd3;
    localparam logic [2:0] PORT_LOCAL = 3'd4;

    localparam logic [COORD_W-1:0] MY_X = ADDRESS[2*COORD_W-1:COORD_W];
    localparam logic [COORD_W-1:0] MY_Y = ADDRESS[COORD_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARBIT = 3'd1,
        S_ROUTE = 3'd2,
        S_GRANT = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [CH_W-1:0]          sel_r;
    logic [CH_W-1:0]          next_sel_s;
    logic [NCH-1:0]           free_r;
    logic [NCH-1:0]           sending_r;
    logic [NCH-1:0][2:0]      outport_r;
    logic [NCH-1:0][CH_W-1:0] inport_r;
    logic [NCH-1:0]           ack_s;
    logic [NCH-1:0]           rel_mask_s;
    logic [NCH-1:0]           grant_mask_s;
    logic [COORD_W-1:0]       tx_s;
    logic [COORD_W-1:0]       ty_s;
    logic                     force_s;
    logic [2:0]               fport_s;
    logic [2:0]               route_s;
    logic [CH_W-1:0]          och_s;
    logic                     unused_flit_s;

    // Output channel index for a given port, keeping the virtual channel number.
    function automatic logic [CH_W-1:0] out_chan(input logic [2:0] port, input int vc);
        return CH_W'(int'(port) * int'(NVC) + vc);
    endfunction

    assign tx_s          = data_i[sel_r][2*COORD_W-1:COORD_W];
    assign ty_s          = data_i[sel_r][COORD_W-1:0];
    assign force_s       = data_i[sel_r][FLIT_SIZE-1];
    assign fport_s       = data_i[sel_r][FLIT_SIZE-2:FLIT_SIZE-4];
    assign unused_flit_s = ^data_i;

    // Route decode of the selected header; comparisons are unsigned.
    always_comb begin
        route_s = PORT_LOCAL;
        if (force_s) begin
            route_s = (fport_s > PORT_LOCAL) ? PORT_LOCAL : fport_s;
        end else if (YX_ROUTING == 0) begin
            if (tx_s != MY_X) begin
                route_s = (tx_s > MY_X) ? PORT_EAST : PORT_WEST;
            end else if (ty_s != MY_Y) begin
                route_s = (ty_s > MY_Y) ? PORT_NORTH : PORT_SOUTH;
            end else begin
                route_s = PORT_LOCAL;
            end
        end else begin
            if (ty_s != MY_Y) begin
                route_s = (ty_s > MY_Y) ? PORT_NORTH : PORT_SOUTH;
            end else if (tx_s != MY_X) begin
                route_s = (tx_s > MY_X) ? PORT_EAST : PORT_WEST;
            end else begin
                route_s = PORT_LOCAL;
            end
        end
    end

    assign och_s = out_chan(route_s, int'(sel_r) % int'(NVC));

    // Round-robin: scanning from farthest to nearest leaves the first requester after sel.
    always_comb begin : rr_next
        int idx;
        next_sel_s = sel_r;
        idx        = 0;
        for (int i = int'(NCH); i >= 1; i--) begin
            idx        = (int'(sel_r) + i >= int'(NCH)) ? int'(sel_r) + i - int'(NCH) : int'(sel_r) + i;
            next_sel_s = req_i[idx] ? CH_W'(idx) : next_sel_s;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = S_IDLE;
        case (state_r)
            S_IDLE:  state_next_s = (|req_i) ? S_ARBIT : S_IDLE;
            S_ARBIT: state_next_s = S_ROUTE;
            S_ROUTE: begin
                if (!req_i[sel_r]) begin
                    state_next_s = S_IDLE;
                end else if (free_r[och_s]) begin
                    state_next_s = S_GRANT;
                end else begin
                    state_next_s = S_ARBIT;
                end
            end
            S_GRANT: state_next_s = S_ACK;
            S_ACK:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output logic: single-cycle grant pulse to the selected channel.
    always_comb begin
        ack_s = '0;
        if (state_r == S_ACK) begin
            ack_s[sel_r] = 1'b1;
        end else begin
            ack_s = '0;
        end
    end

    // Release and allocation masks; a grant clear overrides a release of the same channel.
    always_comb begin
        rel_mask_s   = '0;
        grant_mask_s = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            rel_mask_s[out_chan(outport_r[c], c % int'(NVC))] =
                rel_mask_s[out_chan(outport_r[c], c % int'(NVC))] | (sending_r[c] & ~sending_i[c]);
        end
        grant_mask_s[och_s] = (state_r == S_GRANT);
    end

    // Arbiter pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_r <= '0;
        end else if (state_r == S_ARBIT) begin
            sel_r <= next_sel_s;
        end else begin
            sel_r <= sel_r;
        end
    end

    // Allocation tables and end-of-packet detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_r    <= '1;
            sending_r <= '0;
            outport_r <= '0;
            inport_r  <= '0;
        end else begin
            sending_r <= sending_i;
            free_r    <= (free_r | rel_mask_s) & ~grant_mask_s;
            if (state_r == S_GRANT) begin
                outport_r[sel_r] <= route_s;
                inport_r[och_s]  <= sel_r;
            end else begin
                outport_r <= outport_r;
                inport_r  <= inport_r;
            end
        end
    end

    assign ack_o     = ack_s;
    assign free_o    = free_r;
    assign outport_o = outport_r;
    assign inport_o  = inport_r;

endmodule

// File: tb/tb_hermes_vc_switch.sv
// Directed bench for hermes_vc_switch: an XY and a YX instance share stimulus;
// table of single-request routes plus arbitration, blocking and reset sequences.
module tb_hermes_vc_switch;

    localparam int NCH  = 10;
    localparam int CH_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NCH-1:0]         req;
    logic [NCH-1:0]         sending;
    logic [NCH-1:0][31:0]   data;
    logic [NCH-1:0]         ack_xy, ack_yx, free_xy, free_yx;
    logic [NCH-1:0][2:0]    outport_xy, outport_yx;
    logic [NCH-1:0][CH_W-1:0] inport_xy, inport_yx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          ch;
        logic [31:0] flit;
        int          port_xy;
        int          och_xy;
        int          port_yx;
        int          och_yx;
    } vec_t;

    vec_t vecs[10];

    hermes_vc_switch #(.COORD_W(8), .ADDRESS(16'h0101), .FLIT_SIZE(32), .NVC(2), .YX_ROUTING(0)) dut_xy (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .sending_i(sending), .data_i(data),
        .ack_o(ack_xy), .free_o(free_xy), .outport_o(outport_xy), .inport_o(inport_xy));

    hermes_vc_switch #(.COORD_W(8), .ADDRESS(16'h0101), .FLIT_SIZE(32), .NVC(2), .YX_ROUTING(1)) dut_yx (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .sending_i(sending), .data_i(data),
        .ack_o(ack_yx), .free_o(free_yx), .outport_o(outport_yx), .inport_o(inport_yx));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        req     = '0;
        sending = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits up to maxc falling edges for an ack on the XY instance; cyc = -1 on timeout.
    task automatic wait_ack(input int maxc, output int cyc, output logic [NCH-1:0] a_xy,
                            output logic [NCH-1:0] a_yx);
        cyc  = -1;
        a_xy = '0;
        a_yx = '0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (ack_xy != '0) begin
                cyc  = i;
                a_xy = ack_xy;
                a_yx = ack_yx;
                break;
            end
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int             cyc;
        logic [NCH-1:0] a_xy, a_yx, oh;
        oh = 10'd1 << v.ch;
        @(negedge clk);
        req[v.ch]  = 1'b1;
        data[v.ch] = v.flit;
        wait_ack(12, cyc, a_xy, a_yx);
        check($sformatf("v%0d latency", n), cyc, 4);
        check($sformatf("v%0d ack_xy", n), a_xy, oh);
        check($sformatf("v%0d ack_yx", n), a_yx, oh);
        check($sformatf("v%0d outport_xy", n), outport_xy[v.ch], v.port_xy);
        check($sformatf("v%0d inport_xy", n), inport_xy[v.och_xy], v.ch);
        check($sformatf("v%0d busy_xy", n), free_xy[v.och_xy], 0);
        check($sformatf("v%0d outport_yx", n), outport_yx[v.ch], v.port_yx);
        check($sformatf("v%0d inport_yx", n), inport_yx[v.och_yx], v.ch);
        check($sformatf("v%0d busy_yx", n), free_yx[v.och_yx], 0);
        req[v.ch]     = 1'b0;
        sending[v.ch] = 1'b1;
        @(negedge clk);
        sending[v.ch] = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d release_xy", n), free_xy[v.och_xy], 1);
        check($sformatf("v%0d release_yx", n), free_yx[v.och_yx], 1);
    endtask

    initial begin
        int             cyc, n, last, ch, saw;
        int             exp_seq[4];
        logic [NCH-1:0] a_xy, a_yx;

        // ch, flit, XY port/out-channel, YX port/out-channel; router at X=1, Y=1
        vecs[0] = '{8, 32'h0000_0301, 0, 0, 0, 0};
        vecs[1] = '{1, 32'h0000_0001, 1, 3, 1, 3};
        vecs[2] = '{2, 32'h0000_0105, 2, 4, 2, 4};
        vecs[3] = '{5, 32'h0000_0100, 3, 7, 3, 7};
        vecs[4] = '{6, 32'h0000_0101, 4, 8, 4, 8};
        vecs[5] = '{8, 32'h0000_0303, 0, 0, 2, 4};
        vecs[6] = '{3, 32'hF000_0301, 4, 9, 4, 9};
        vecs[7] = '{0, 32'hB000_0301, 3, 6, 3, 6};
        vecs[8] = '{4, 32'h0000_FF01, 0, 0, 0, 0};
        vecs[9] = '{9, 32'h0000_0000, 1, 3, 3, 7};
        exp_seq = '{3, 9, 0, 3};

        rst_n   = 1'b0;
        req     = '0;
        sending = '0;
        data    = '0;
        do_reset();
        #1;
        check("rst ack_xy", ack_xy, 0);
        check("rst free_xy", free_xy, 10'h3FF);
        check("rst outport_xy", outport_xy, 0);
        check("rst inport_xy", inport_xy, 0);
        check("rst free_yx", free_yx, 10'h3FF);

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Round-robin with channels 0, 3 and 9 requesting continuously.
        do_reset();
        data[0] = 32'h0000_0101;
        data[3] = 32'h0000_0301;
        data[9] = 32'h0000_0001;
        req     = 10'b10_0000_1001;
        n       = 0;
        last    = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            sending = '0;
            if (ack_xy != '0) begin
                ch = 0;
                for (int k = 0; k < NCH; k++) begin
                    if (ack_xy[k]) ch = k;
                end
                check($sformatf("rr onehot %0d", n), $countones(ack_xy), 1);
                check($sformatf("rr order %0d", n), ch, exp_seq[n]);
                if (n > 0) check($sformatf("rr gap %0d", n), i - last, 5);
                last        = i;
                sending[ch] = 1'b1;
                n++;
            end
        end
        check("rr grants", n, 4);
        req = '0;

        // Blocked output channel 0: channel 4 holds EAST vc0.
        do_reset();
        data[4] = 32'h0000_0301;
        req[4]  = 1'b1;
        wait_ack(12, cyc, a_xy, a_yx);
        check("blk holder ack", a_xy, 10'd1 << 4);
        req[4]     = 1'b0;
        sending[4] = 1'b1;
        @(negedge clk);
        check("blk och0 busy", free_xy[0], 0);
        data[8] = 32'h0000_0301;
        data[2] = 32'h0000_0101;
        req[8]  = 1'b1;
        req[2]  = 1'b1;
        wait_ack(20, cyc, a_xy, a_yx);
        check("blk skip ack", a_xy, 10'd1 << 2);
        check("blk skip latency", cyc, 6);
        check("blk skip outport", outport_xy[2], 4);
        req[2] = 1'b0;
        saw    = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack_xy != '0) saw = 1;
        end
        check("blk still blocked", saw, 0);
        sending[4] = 1'b0;
        @(negedge clk);
        check("blk released", free_xy[0], 1);
        wait_ack(12, cyc, a_xy, a_yx);
        check("blk late ack", a_xy, 10'd1 << 8);
        check("blk late outport", outport_xy[8], 0);
        check("blk late inport", inport_xy[0], 8);
        check("blk late busy", free_xy[0], 0);
        req[8] = 1'b0;
        @(negedge clk);

        // Reset asserted during GRANT discards the grant.
        data[1] = 32'h0000_0001;
        req[1]  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid rst ack", ack_xy, 0);
        check("mid rst free", free_xy, 10'h3FF);
        check("mid rst outport", outport_xy, 0);
        @(negedge clk);
        check("mid rst no ack", ack_xy | ack_yx, 0);
        rst_n = 1'b1;
        wait_ack(12, cyc, a_xy, a_yx);
        check("post rst latency", cyc, 4);
        check("post rst ack", a_xy, 10'd1 << 1);
        check("post rst outport", outport_xy[1], 1);
        check("post rst inport", inport_xy[3], 1);
        req[1] = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
